// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and FSM encoding for the instruction fetch stage
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int CNT_W_DEF   = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_HOLD = S_HOLD
  } fetch_state_e;

endpackage

// File: rtl/instr_reg.sv
// rtl/instr_reg.sv - instruction register with load enable and async active-low clear
module instr_reg
  import fetch_pkg::*;
#(
  parameter int W = INSTR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch FSM: memory req/ack, instruction hand-off to decode, PC advance
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_enable,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               flush,
  input  logic               halt,
  output logic [CNT_W-1:0]   fetch_cnt
);

  fetch_state_e state, state_nxt;
  logic         drop;

  logic capture;
  logic load_addr;
  logic retire;
  logic kill_ir;
  logic drop_set;
  logic drop_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!halt) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack) state_nxt = (drop || flush) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        // flush takes priority over a same-cycle accept
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (ir_ready) begin
          state_nxt = halt ? ST_IDLE : ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    pc_enable = 1'b0;
    capture   = 1'b0;
    load_addr = 1'b0;
    retire    = 1'b0;
    kill_ir   = 1'b0;
    drop_set  = 1'b0;
    drop_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_addr = !halt;
      end
      ST_REQ: begin
        mem_req   = 1'b1;
        capture   = mem_ack && !drop && !flush;
        pc_enable = capture;
        drop_clr  = mem_ack;
        drop_set  = flush && !mem_ack;
      end
      ST_HOLD: begin
        retire    = ir_ready && !flush;
        kill_ir   = flush;
        load_addr = retire && !halt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= '0;
    end else if (load_addr) begin
      mem_addr <= pc_in;
    end
  end

  // A flush seen while the request is still outstanding poisons the eventual ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop <= 1'b0;
    end else if (drop_clr) begin
      drop <= 1'b0;
    end else if (drop_set) begin
      drop <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_valid <= 1'b0;
    end else if (capture) begin
      ir_valid <= 1'b1;
    end else if (retire || kill_ir) begin
      ir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
    end else if (retire) begin
      fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

  instr_reg #(
    .W(INSTR_W)
  ) u_instr_reg (
    .clk  (clk),
    .reset(reset),
    .load (capture),
    .d    (mem_rdata),
    .q    (ir_out)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench: pc model + 1-cycle-ack ROM around fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic        pc_enable;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_data = 16'h0000;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        flush;
  logic        halt;
  logic [15:0] fetch_cnt;

  logic        pc_load;
  logic [7:0]  pc_load_val;
  int          pe_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          pe_base;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W (8),
    .INSTR_W(16),
    .CNT_W  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_in    (pc),
    .pc_enable(pc_enable),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (rom_ack),
    .mem_rdata(rom_data),
    .ir_out   (ir_out),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .flush    (flush),
    .halt     (halt),
    .fetch_cnt(fetch_cnt)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 8'h00;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_enable) pc <= pc + 8'h01;
  end

  always @(posedge clk) begin
    rom_ack  <= mem_req && !rom_ack;
    rom_data <= 16'hA000 + {8'h00, mem_addr};
    if (pc_enable) pe_cnt <= pe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ir_valid && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(ir_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b0; ir_ready = 1'b0; flush = 1'b0; halt = 1'b0;
    pc_load = 1'b0; pc_load_val = 8'h00;
    tick(); tick();
    check("rst_req",   32'(mem_req),   32'd0);
    check("rst_valid", 32'(ir_valid),  32'd0);
    check("rst_cnt",   32'(fetch_cnt), 32'd0);
    check("rst_ir",    32'(ir_out),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_pe",    32'(pc_enable), 32'd0);

    // 1: first fetch, cycle exact
    ir_ready = 1'b1;
    pe_base = pe_cnt;
    reset = 1'b1;
    tick();
    check("t1_req",  32'(mem_req),   32'd1);
    check("t1_addr", 32'(mem_addr),  32'h00);
    check("t1_pe0",  32'(pc_enable), 32'd0);
    tick();
    check("t1_pe1",  32'(pc_enable), 32'd1);
    tick();
    check("t1_valid", 32'(ir_valid), 32'd1);
    check("t1_ir",    32'(ir_out),   32'hA000);
    check("t1_pc",    32'(pc),       32'h01);
    check("t1_req0",  32'(mem_req),  32'd0);

    // 2: three back-to-back instructions
    for (int i = 0; i < 3; i++) begin
      wait_valid("t2");
      check("t2_ir", 32'(ir_out), 32'hA000 + 32'(i));
      tick();
    end
    check("t2_cnt", 32'(fetch_cnt), 32'd3);
    check("t2_pc",  32'(pc),        32'h03);
    check("t2_pe",  32'(pe_cnt - pe_base), 32'd3);

    // 3: decode stalls in HOLD
    ir_ready = 1'b0;
    wait_valid("t3");
    check("t3_ir", 32'(ir_out), 32'hA003);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_valid", 32'(ir_valid), 32'd1);
      check("t3_ir_hold", 32'(ir_out), 32'hA003);
      check("t3_req", 32'(mem_req), 32'd0);
      check("t3_pc", 32'(pc), 32'h04);
    end
    ir_ready = 1'b1;
    tick();
    check("t3_cnt",  32'(fetch_cnt), 32'd4);
    check("t3_addr", 32'(mem_addr),  32'h04);

    // 4: flush during REQ before the ack, control loads pc=0A
    pe_base = pe_cnt;
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 8'h0A;
    check("t4_pe_flush", 32'(pc_enable), 32'd0);
    tick();
    flush = 1'b0; pc_load = 1'b0;
    check("t4_stale_ack", 32'(rom_ack), 32'd1);
    check("t4_pe_drop", 32'(pc_enable), 32'd0);
    tick();
    check("t4_idle_req", 32'(mem_req), 32'd0);
    check("t4_ir_kept", 32'(ir_valid), 32'd0);
    tick();
    check("t4_req",  32'(mem_req),  32'd1);
    check("t4_addr", 32'(mem_addr), 32'h0A);
    wait_valid("t4");
    check("t4_ir", 32'(ir_out), 32'hA00A);
    check("t4_pe", 32'(pe_cnt - pe_base), 32'd1);
    check("t4_pc", 32'(pc), 32'h0B);

    // 5: halt while HOLD, accepted, then idle until released
    halt = 1'b1;
    tick();
    check("t5_valid", 32'(ir_valid),  32'd0);
    check("t5_cnt",   32'(fetch_cnt), 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_req_idle", 32'(mem_req), 32'd0);
    end
    halt = 1'b0;
    tick();
    check("t5_req",  32'(mem_req),  32'd1);
    check("t5_addr", 32'(mem_addr), 32'h0B);

    // 6: async reset while the ack is on the bus
    tick();
    check("t6_ack", 32'(rom_ack), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_req",   32'(mem_req),   32'd0);
    check("t6_valid", 32'(ir_valid),  32'd0);
    check("t6_cnt",   32'(fetch_cnt), 32'd0);
    check("t6_pe",    32'(pc_enable), 32'd0);
    #2;
    reset = 1'b1;
    tick();
    check("t6_late_ack", 32'(ir_valid), 32'd0);
    check("t6_req2",  32'(mem_req),  32'd1);
    check("t6_addr",  32'(mem_addr), 32'h00);
    wait_valid("t6");
    check("t6_ir", 32'(ir_out), 32'hA000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
